// File: rtl/aca_pkg.sv
// Shared definitions for the ACA-I variable-latency adder slice.
//   state_t : controller states
//   ACA_W   : default operand width
//   ACA_Q   : default carry window width
//   clog2   : bit width needed to hold values 0..value-1
package aca_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPROX,
        CORR,
        OUT
    } state_t;

    localparam int ACA_W = 16;
    localparam int ACA_Q = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/aca_vl_adder_ctrl_if.sv
// Operand/result bus of aca_vl_adder_ctrl.
//   in_valid/in_ready    : operand handshake, in1/in2 operands, exact_mode
//   out_valid/out_ready  : result handshake, res/res_err/res_corrected
//   clr_stats/err_count  : error-event statistics
// master: the producer/consumer side; slave: the adder controller.
interface aca_vl_adder_ctrl_if #(
    parameter int W     = 16,
    parameter int CNT_W = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in1;
    logic [W-1:0]     in2;
    logic             exact_mode;
    logic             out_valid;
    logic             out_ready;
    logic [W:0]       res;
    logic             res_err;
    logic             res_corrected;
    logic             clr_stats;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in1, in2, exact_mode, out_ready, clr_stats,
        input  in_ready, out_valid, res, res_err, res_corrected, err_count
    );

    modport slave (
        input  in_valid, in1, in2, exact_mode, out_ready, clr_stats,
        output in_ready, out_valid, res, res_err, res_corrected, err_count
    );

endinterface

// File: rtl/aca_approx_core.sv
// Combinational ACA-I approximate adder.
//   a, b   : W-bit operands
//   approx : W+1-bit approximate sum; each bit at or above Q only sees the
//            carry generated inside the Q-1 bits directly below it
//   err    : approx differs from the exact W+1-bit sum
module aca_approx_core
    import aca_pkg::*;
#(
    parameter int W = ACA_W,
    parameter int Q = ACA_Q
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   approx,
    output logic         err
);

    logic [Q-1:0] low_sum;
    logic [Q:0]   top_sum;
    logic [W:0]   exact_sum;

    // Low Q bits are computed exactly.
    assign low_sum          = a[Q-1:0] + b[Q-1:0];
    assign approx[Q-1:0]    = low_sum;

    // MSB is the carry-out of the top Q-bit window.
    assign top_sum          = {1'b0, a[W-1 -: Q]} + {1'b0, b[W-1 -: Q]};
    assign approx[W]        = top_sum[Q];

    genvar k;
    generate
        for (k = Q; k < W; k++) begin : g_win
            logic [Q-1:0] win;
            // Q-1 bit window k-Q+1..k-1, carry-in 0; its carry-out is win[Q-1].
            assign win       = {1'b0, a[k-1 -: Q-1]} + {1'b0, b[k-1 -: Q-1]};
            assign approx[k] = a[k] ^ b[k] ^ win[Q-1];
        end
    endgenerate

    assign exact_sum = {1'b0, a} + {1'b0, b};
    assign err       = (approx != exact_sum);

endmodule

// File: rtl/aca_vl_adder_ctrl.sv
// Variable-latency sequencer around the ACA-I approximate adder.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : operand handshake (in_*), result handshake (out_*, res*),
//              statistics (clr_stats, err_count)
// One operation in flight: IDLE accepts, APPROX registers the approximate
// sum, CORR (exact mode with error) spends CORR_CYCLES producing the exact
// sum, OUT holds the result until out_ready.
module aca_vl_adder_ctrl
    import aca_pkg::*;
#(
    parameter int W           = ACA_W,
    parameter int Q           = ACA_Q,
    parameter int CORR_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    aca_vl_adder_ctrl_if.slave bus
);

    localparam int CW = clog2(CORR_CYCLES + 1);

    state_t           state_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             mode_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [W:0]       res_q;
    logic             res_err_q;
    logic             res_corr_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    logic [W:0]       approx;
    logic             err;
    logic [W:0]       exact_sum;

    aca_approx_core #(
        .W(W),
        .Q(Q)
    ) u_core (
        .a      (a_q),
        .b      (b_q),
        .approx (approx),
        .err    (err)
    );

    assign exact_sum = {1'b0, a_q} + {1'b0, b_q};

    // Clear wins over a same-cycle error event; counter sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.clr_stats) begin
            err_cnt_d = '0;
        end else if (state_q == APPROX && err && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            res_err_q   <= 1'b0;
            res_corr_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.in1;
                        b_q        <= bus.in2;
                        mode_q     <= bus.exact_mode;
                        in_ready_q <= 1'b0;
                        state_q    <= APPROX;
                    end
                end
                APPROX: begin
                    res_q      <= approx;
                    res_err_q  <= err;
                    res_corr_q <= 1'b0;
                    if (err && mode_q) begin
                        cnt_q   <= CW'(CORR_CYCLES - 1);
                        state_q <= CORR;
                    end else begin
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                CORR: begin
                    if (cnt_q == '0) begin
                        res_q       <= exact_sum;
                        res_corr_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.res           = res_q;
    assign bus.res_err       = res_err_q;
    assign bus.res_corrected = res_corr_q;
    assign bus.err_count     = err_cnt_q;

endmodule

// File: tb/tb_aca_vl_adder_ctrl.sv
// Scoreboard bench for aca_vl_adder_ctrl. dut0: CORR_CYCLES=1, CNT_W=16;
// dut1: CORR_CYCLES=3, CNT_W=2. Expected results are queued at accept and
// popped by a negedge monitor when out_valid appears.
module tb_aca_vl_adder_ctrl;

    typedef struct {
        logic [16:0] res;
        logic        err;
        logic        corr;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int cnt0   = 0;
    int cnt1   = 0;

    exp_t q0[$];
    exp_t q1[$];
    bit   seen[2];
    bit   have[2];
    exp_t cur[2];

    aca_vl_adder_ctrl_if #(.W(16), .CNT_W(16)) bus0();
    aca_vl_adder_ctrl_if #(.W(16), .CNT_W(2))  bus1();

    aca_vl_adder_ctrl #(.W(16), .Q(4), .CORR_CYCLES(1), .CNT_W(16)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    aca_vl_adder_ctrl #(.W(16), .Q(4), .CORR_CYCLES(3), .CNT_W(2)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    task automatic mon_step(input int id, input logic ov, input logic ir,
                            input logic [16:0] r, input logic e, input logic c);
        exp_t x;
        bit   empty;
        if (!ov) begin
            seen[id] = 1'b0;
            return;
        end
        chk("in_ready_during_out", id, 32'(ir), 32'd0);
        if (!seen[id]) begin
            seen[id] = 1'b1;
            empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                have[id] = 1'b0;
                $display("FAIL stray_out dut%0d: got out_valid with res=%0h expected no output", id, r);
            end else begin
                if (id == 0) x = q0.pop_front();
                else         x = q1.pop_front();
                cur[id]  = x;
                have[id] = 1'b1;
                chk("latency", id, 32'(cyc - x.acc + 1), 32'(x.lat));
                chk("res", id, 32'(r), 32'(x.res));
                chk("res_err", id, 32'(e), 32'(x.err));
                chk("res_corrected", id, 32'(c), 32'(x.corr));
            end
        end else if (have[id]) begin
            chk("res_stable", id, 32'(r), 32'(cur[id].res));
            chk("res_err_stable", id, 32'(e), 32'(cur[id].err));
            chk("res_corrected_stable", id, 32'(c), 32'(cur[id].corr));
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, bus0.out_valid, bus0.in_ready, bus0.res, bus0.res_err, bus0.res_corrected);
        mon_step(1, bus1.out_valid, bus1.in_ready, bus1.res, bus1.res_err, bus1.res_corrected);
    end

    function automatic logic rdy_of(input int id);
        return (id == 0) ? bus0.in_ready : bus1.in_ready;
    endfunction

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        while (!rdy_of(id) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy_of(id)) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout dut%0d: got in_ready=0 expected 1 within 100 cycles", id);
        end
    endtask

    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic m,
                         input logic [16:0] r, input logic e, input logic c);
        exp_t x;
        wait_idle(id);
        if (id == 0) begin
            bus0.in1 = a; bus0.in2 = b; bus0.exact_mode = m; bus0.in_valid = 1'b1;
        end else begin
            bus1.in1 = a; bus1.in2 = b; bus1.exact_mode = m; bus1.in_valid = 1'b1;
        end
        @(posedge clk); #1;
        // Scramble operands after accept; the DUT must use the latched copy.
        if (id == 0) begin
            bus0.in_valid = 1'b0; bus0.in1 = ~a; bus0.in2 = ~b; bus0.exact_mode = ~m;
        end else begin
            bus1.in_valid = 1'b0; bus1.in1 = ~a; bus1.in2 = ~b; bus1.exact_mode = ~m;
        end
        x.res  = r;
        x.err  = e;
        x.corr = c;
        x.acc  = cyc;
        x.lat  = (e && m) ? 2 + ((id == 0) ? 1 : 3) : 2;
        if (id == 0) q0.push_back(x);
        else         q1.push_back(x);
    endtask

    task automatic chk_reset(input int id);
        if (id == 0) begin
            chk("rst_out_valid", 0, 32'(bus0.out_valid), 32'd0);
            chk("rst_in_ready", 0, 32'(bus0.in_ready), 32'd1);
            chk("rst_res", 0, 32'(bus0.res), 32'd0);
            chk("rst_res_err", 0, 32'(bus0.res_err), 32'd0);
            chk("rst_res_corrected", 0, 32'(bus0.res_corrected), 32'd0);
            chk("rst_err_count", 0, 32'(bus0.err_count), 32'd0);
        end else begin
            chk("rst_out_valid", 1, 32'(bus1.out_valid), 32'd0);
            chk("rst_in_ready", 1, 32'(bus1.in_ready), 32'd1);
            chk("rst_res", 1, 32'(bus1.res), 32'd0);
            chk("rst_res_err", 1, 32'(bus1.res_err), 32'd0);
            chk("rst_res_corrected", 1, 32'(bus1.res_corrected), 32'd0);
            chk("rst_err_count", 1, 32'(bus1.err_count), 32'd0);
        end
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.in_valid = 1'b0; bus0.in1 = '0; bus0.in2 = '0; bus0.exact_mode = 1'b0;
        bus0.out_ready = 1'b1; bus0.clr_stats = 1'b0;
        bus1.in_valid = 1'b0; bus1.in1 = '0; bus1.in2 = '0; bus1.exact_mode = 1'b0;
        bus1.out_ready = 1'b1; bus1.clr_stats = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(posedge clk); #1;

        // dut0: approximate vs exact mode on a long carry chain.
        issue(0, 16'h00FF, 16'h0001, 1'b0, 17'h000F0, 1'b1, 1'b0);
        cnt0 = cnt0 + 1;
        wait_idle(0);
        chk("err_count", 0, 32'(bus0.err_count), 32'(cnt0));
        issue(0, 16'h00FF, 16'h0001, 1'b1, 17'h00100, 1'b1, 1'b1);
        cnt0 = cnt0 + 1;
        issue(0, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFE, 1'b0, 1'b0);
        issue(0, 16'h1234, 16'h1111, 1'b1, 17'h02345, 1'b0, 1'b0);
        issue(0, 16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b0, 1'b0);
        issue(0, 16'h0FF0, 16'h0010, 1'b0, 17'h00F00, 1'b1, 1'b0);
        cnt0 = cnt0 + 1;
        wait_idle(0);
        chk("err_count", 0, 32'(bus0.err_count), 32'(cnt0));

        // dut0: backpressure with ignored in_valid pulses.
        bus0.out_ready = 1'b0;
        issue(0, 16'h1234, 16'h1111, 1'b0, 17'h02345, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            bus0.in_valid   = i[0];
            bus0.in1        = 16'h00FF;
            bus0.in2        = 16'h0001;
            bus0.exact_mode = 1'b1;
            @(posedge clk); #1;
        end
        bus0.in_valid = 1'b0;
        chk("stall_out_valid", 0, 32'(bus0.out_valid), 32'd1);
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 0, 32'(bus0.in_ready), 32'd1);
        chk("release_out_valid", 0, 32'(bus0.out_valid), 32'd0);
        chk("err_count", 0, 32'(bus0.err_count), 32'(cnt0));

        // dut1: saturating 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            issue(1, 16'h00FF, 16'h0001, 1'b0, 17'h000F0, 1'b1, 1'b0);
            cnt1 = (cnt1 < 3) ? cnt1 + 1 : 3;
            wait_idle(1);
            chk("err_count_sat", 1, 32'(bus1.err_count), 32'(cnt1));
        end

        // dut1: clear coincident with an error event.
        issue(1, 16'h00FF, 16'h0001, 1'b0, 17'h000F0, 1'b1, 1'b0);
        bus1.clr_stats = 1'b1;
        @(posedge clk); #1;
        bus1.clr_stats = 1'b0;
        cnt1 = 0;
        wait_idle(1);
        chk("err_count_clr", 1, 32'(bus1.err_count), 32'(cnt1));

        // dut1: full correction pass with CORR_CYCLES=3.
        issue(1, 16'h00FF, 16'h0001, 1'b1, 17'h00100, 1'b1, 1'b1);
        cnt1 = cnt1 + 1;
        wait_idle(1);
        chk("err_count", 1, 32'(bus1.err_count), 32'(cnt1));

        // dut1: reset while in CORR discards the operation.
        issue(1, 16'h00FF, 16'h0001, 1'b1, 17'h00100, 1'b1, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst1 = 1'b1;
        #1;
        q1.delete();
        cnt1 = 0;
        chk_reset(1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        issue(1, 16'h1234, 16'h1111, 1'b1, 17'h02345, 1'b0, 1'b0);
        wait_idle(1);
        chk("err_count_after_rst", 1, 32'(bus1.err_count), 32'(cnt1));

        repeat (5) @(posedge clk);
        #1;
        chk("pending_outputs", 0, 32'(q0.size()), 32'd0);
        chk("pending_outputs", 1, 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish before 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
